// File: rtl/stream_fanout_buffer.sv
// Broadcast repeater: one valid/ready source feeds a masked subset of load channels,
// each with its own DEPTH-entry FIFO so a stalled load cannot corrupt the others.
module stream_fanout_buffer #(
    parameter int WIDTH      = 8,
    parameter int NUM_LOADS  = 2,
    parameter int DEPTH      = 2,
    parameter int DROP_CNT_W = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [WIDTH-1:0]                       in_data,
    input  logic [NUM_LOADS-1:0]                   in_mask,
    output logic [NUM_LOADS-1:0]                   out_valid,
    input  logic [NUM_LOADS-1:0]                   out_ready,
    output logic [NUM_LOADS*WIDTH-1:0]             out_data,
    output logic [NUM_LOADS*($clog2(DEPTH)+1)-1:0] fill,
    output logic                                   busy,
    output logic [DROP_CNT_W-1:0]                  drop_cnt
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W = $clog2(DEPTH) + 1;

    logic [NUM_LOADS-1:0] space;
    logic                 accept;

    // Space comes from registered occupancy only, so out_ready never reaches in_ready.
    always_comb begin
        in_ready = &(~in_mask | space);
        accept   = in_valid & in_ready;
        busy     = |out_valid;
    end

    for (genvar g = 0; g < NUM_LOADS; g++) begin : g_ch
        logic [WIDTH-1:0]  mem [DEPTH];
        logic [PTR_W-1:0]  rd_ptr;
        logic [PTR_W-1:0]  wr_ptr;
        logic [FILL_W-1:0] cnt;
        logic              push;
        logic              pop;
        logic [PTR_W-1:0]  rd_nxt;
        logic [PTR_W-1:0]  wr_nxt;

        always_comb begin
            push           = accept & in_mask[g];
            pop            = out_valid[g] & out_ready[g];
            space[g]       = (cnt < FILL_W'(DEPTH));
            out_valid[g]   = (cnt != '0);
            rd_nxt         = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            wr_nxt         = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            fill[g*FILL_W +: FILL_W] = cnt;
            // Gate with valid so a freshly reset channel reads zero regardless of stale storage.
            out_data[g*WIDTH +: WIDTH] = out_valid[g] ? mem[rd_ptr] : '0;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push) wr_ptr <= wr_nxt;
                if (pop)  rd_ptr <= rd_nxt;
                case ({push, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (accept && (in_mask == '0) && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule
